// File: rtl/booth_mul_dp_pkg.sv
// Shared constants for the radix-2 Booth multiplier: control-vector and status-vector bit positions.
// Imported by the datapath, its interface and the control unit.
package booth_mul_pkg;

  localparam int CTL_W = 10;
  localparam int ST_W  = 2;

  localparam int CTL_LD_A     = 9;
  localparam int CTL_LD_B     = 8;
  localparam int CTL_LD_CONT  = 7;
  localparam int CTL_SET_EF   = 6;
  localparam int CTL_RST_X    = 5;
  localparam int CTL_RST_EF   = 4;
  localparam int CTL_SUB_X    = 3;
  localparam int CTL_SUB_CONT = 2;
  localparam int CTL_ADD_X    = 1;
  localparam int CTL_SHIFT_XB = 0;

  localparam int ST_B0  = 1;
  localparam int ST_FIN = 0;

  typedef logic [CTL_W-1:0] ctl_t;
  typedef logic [ST_W-1:0]  st_t;

endpackage

// File: rtl/booth_mul_dp_if.sv
// Bus between the Booth multiplier datapath and its control unit / product consumer.
// master = control unit side, slave = datapath side.
interface booth_mul_dp_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]           a_in;
  logic [WIDTH-1:0]           b_in;
  booth_mul_pkg::ctl_t        control;
  booth_mul_pkg::st_t         status;
  logic [2*WIDTH-1:0]         product;
  logic                       done;

  modport master (
    output a_in,
    output b_in,
    output control,
    input  status,
    input  product,
    input  done
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  control,
    output status,
    output product,
    output done
  );

endinterface

// File: rtl/booth_mul_dp_addsub.sv
// Combinational (WIDTH+1)-bit two's-complement adder/subtractor used for the Booth accumulator.
module booth_addsub #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH:0] a,
  input  logic signed [WIDTH:0] b,
  input  logic                  sub,
  output logic signed [WIDTH:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mul_dp.sv
// Radix-2 Booth signed multiplier datapath, slaved to the 10-bit control vector.
// Optional macro BOOTH_MUL_DP_CHK_EN adds a sticky ctl_err output flagging illegal control combinations.
module booth_mul_dp
  import booth_mul_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic           clk,
  input  logic           rstn,
  booth_mul_dp_if.slave  bus
`ifdef BOOTH_MUL_DP_CHK_EN
  ,
  output logic           ctl_err
`endif
);

  ctl_t                    ctl;
  logic signed [WIDTH-1:0] a_q;
  logic        [WIDTH-1:0] b_q;
  logic signed [WIDTH:0]   x_q;
  logic        [CW-1:0]    cnt_q;
  logic                    ef_q;

  logic signed [WIDTH:0]   a_ext;
  logic signed [WIDTH:0]   x_sum;
  logic signed [WIDTH:0]   x_arith;
  logic signed [WIDTH:0]   x_shift;
  logic                    arith_en;
  logic                    fin;

  assign ctl = bus.control;

  // A is widened by one bit so that subtracting the most-negative multiplicand cannot overflow X.
  assign a_ext = {a_q[WIDTH-1], a_q};

  booth_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (x_q),
    .b   (a_ext),
    .sub (ctl[CTL_SUB_X]),
    .y   (x_sum)
  );

  // Simultaneous ADD and SUB cancel out: X holds instead of taking either result.
  assign arith_en = ctl[CTL_ADD_X] ^ ctl[CTL_SUB_X];
  assign x_arith  = arith_en ? x_sum : x_q;
  assign x_shift  = {x_arith[WIDTH], x_arith[WIDTH:1]};
  assign fin      = (cnt_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q <= '0;
    end else if (ctl[CTL_LD_A]) begin
      a_q <= bus.a_in;
    end
  end

  // The bit shifted out of X into B comes from the same-cycle add/sub result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_q <= '0;
    end else if (ctl[CTL_LD_B]) begin
      b_q <= bus.b_in;
    end else if (ctl[CTL_SHIFT_XB]) begin
      b_q <= {x_arith[0], b_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_q <= '0;
    end else if (ctl[CTL_RST_X]) begin
      x_q <= '0;
    end else if (ctl[CTL_SHIFT_XB]) begin
      x_q <= x_shift;
    end else begin
      x_q <= x_arith;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (ctl[CTL_LD_CONT]) begin
      cnt_q <= CW'(WIDTH);
    end else if (ctl[CTL_SUB_CONT] && !fin) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ef_q <= 1'b0;
    end else if (ctl[CTL_SET_EF]) begin
      ef_q <= 1'b1;
    end else if (ctl[CTL_RST_EF]) begin
      ef_q <= 1'b0;
    end
  end

`ifdef BOOTH_MUL_DP_CHK_EN
  logic err_set;

  // A new violation in the same cycle as RST_EF keeps the flag raised.
  assign err_set = (ctl[CTL_ADD_X] & ctl[CTL_SUB_X])
                 | (ctl[CTL_SHIFT_XB] & fin)
                 | ((ctl[CTL_ADD_X] | ctl[CTL_SUB_X]) & ctl[CTL_LD_A]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl_err <= 1'b0;
    end else if (err_set) begin
      ctl_err <= 1'b1;
    end else if (ctl[CTL_RST_EF]) begin
      ctl_err <= 1'b0;
    end
  end
`endif

  assign bus.status[ST_B0]  = b_q[0];
  assign bus.status[ST_FIN] = fin;
  assign bus.product        = {x_q[WIDTH-1:0], b_q};
  assign bus.done           = ef_q;

endmodule
